memory_path: RTL
================

// Module: memory_path
// PURPOSE
//  Pipeline stage directly downstream of the execute stage. Registers the EX results (EX/MEM) and drives the data-memory bus.
//  Handshakes with a variable-latency data memory and stalls the pipeline until each access completes.
//  Registers the MEM results (MEM/WB) and returns alu_out_M, result_W, reg_id_M/W and reg_write_M/W for forwarding and hazard detection.
// PARAMETERS
//  N               32   datapath width (addr/data)
//  TIMEOUT_CYCLES  16   max wait cycles for dmem_ready before abort; >=1
// PORTS
//  clk            in   1   clock, rising edge
//  reset_n        in   1   async active-low reset
//  alu_out_E      in   N   EX ALU result / memory address
//  write_data_E   in   N   store data (forwarded rt)
//  reg_id_E       in   5   destination register
//  reg_write_E    in   1   instr writes regfile
//  mem_to_reg_E   in   1   instr is load
//  mem_write_E    in   1   instr is store
//  dmem_req       out  1   access request
//  dmem_we        out  1   1=write
//  dmem_addr      out  N   byte address
//  dmem_wdata     out  N   write data
//  dmem_be        out  4   byte lane enables
//  dmem_ready     in   1   access complete this cycle
//  dmem_rdata     in   N   read data, valid with dmem_ready
//  stall_M        out  1   pipeline freeze request to hazard unit
//  mem_err        out  1   1-cycle pulse on timeout abort
//  alu_out_M      out  N   forwarding source (M)
//  reg_id_M       out  5   for hazard unit
//  reg_write_M    out  1   for hazard unit
//  result_W       out  N   mem_to_reg_W ? read_data_W : alu_out_W
//  reg_id_W       out  5   regfile write address
//  reg_write_W    out  1   regfile write enable
// BEHAVIOUR
//  - Reset (async, reset_n=0): EX/MEM, MEM/WB, FSM cleared. All control outputs 0, data outputs 0, FSM=IDLE.
//  - Latency: EX->M 1 cycle, M->W 1 cycle. Zero-wait memory: no stall.
//  - mem_op_M = mem_to_reg_M | mem_write_M. Both set on the same instr is illegal; treat it as a store.
//  - FSM IDLE: dmem_req = mem_op_M.
//      Ready in the same cycle: complete, stay IDLE.
//      Not ready: go to WAIT, counter=1.
//  - FSM WAIT: dmem_req=1, counter++.
//      dmem_ready: complete, go to IDLE.
//      counter==TIMEOUT_CYCLES without ready: abort, mem_err=1 for 1 cycle, load data forced 0, go to IDLE.
//  - stall_M = mem_op_M & ~complete (combinational; asserted from the IDLE cycle of a missed access through the cycle before completion).
//  - While stall_M=1: EX/MEM and MEM/WB hold their contents. A re-write of the same regfile value is harmless.
//      addr, we, wdata and be stay stable for as long as dmem_req is high.
//  - On completion cycle: MEM/WB captures read_data=dmem_rdata (0 on abort); EX/MEM loads the next EX instr.
//  - dmem_ready while dmem_req=0 is ignored. Back-to-back memory ops: req stays high, new addr presented the cycle after completion.
//  - Reset mid-access: FSM to IDLE, req dropped immediately; no mem_err.
// CONFIGURATION
//  MEM_SUBWORD_EN defined:
//    Adds inputs mem_size_E[1:0] (0=byte, 1=half, 2=word) and mem_unsigned_E.
//    Stores: data replicated across lanes; dmem_be from addr[1:0] (byte: 1 lane, half: addr[1] selects pair).
//    Loads: lane extracted, then sign- or zero-extended.
//    Misaligned half/word: treated as word-aligned (addr low bits ignored).
//  MEM_SUBWORD_EN undefined: word access only; dmem_be=4'b1111; dmem_addr low 2 bits passed through unchanged.
// TESTING
//  1. reset_n=0 mid-WAIT -> dmem_req=0, stall_M=0, reg_write_W=0 asynchronously; IDLE after release.
//  2. Load addr 0x10, dmem_ready same cycle, rdata 0xDEADBEEF -> stall_M never high; next cycle result_W=0xDEADBEEF, reg_write_W=1.
//  3. Store 0x1234 to 0x20, ready after 3 cycles -> stall_M high 3 cycles; addr/wdata/we stable throughout; reg_write_W=0.
//  4. Load, dmem_ready never -> mem_err pulses at cycle 16; result_W=0; pipeline resumes.
//  5. ALU instr (reg_write_E=1, alu_out_E=7) then load -> alu_out_M=7, then result_W=7 one cycle later; no dmem_req for ALU instr.
//  6. MEM_SUBWORD_EN: lb at 0x3 with rdata 0x80xxxxxx -> 0xFFFFFF80; sb 0xAB at 0x1 -> be=4'b0010, wdata=0xABABABAB.

Source files
------------

// File: rtl/memory_path.sv
// EX/MEM + MEM/WB pipeline stage with a variable-latency data-memory handshake and timeout abort.
// Optional sub-word (byte/half) loads and stores are compiled in with `define MEM_SUBWORD_EN.
module memory_path #(
  parameter int N              = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] alu_out_E,
  input  logic [N-1:0] write_data_E,
  input  logic [4:0]   reg_id_E,
  input  logic         reg_write_E,
  input  logic         mem_to_reg_E,
  input  logic         mem_write_E,
`ifdef MEM_SUBWORD_EN
  input  logic [1:0]   mem_size_E,
  input  logic         mem_unsigned_E,
`endif
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  output logic [3:0]   dmem_be,
  input  logic         dmem_ready,
  input  logic [N-1:0] dmem_rdata,
  output logic         stall_M,
  output logic         mem_err,
  output logic [N-1:0] alu_out_M,
  output logic [4:0]   reg_id_M,
  output logic         reg_write_M,
  output logic [N-1:0] result_W,
  output logic [4:0]   reg_id_W,
  output logic         reg_write_W
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // EX/MEM contents not exported as ports
  logic [N-1:0] write_data_M;
  logic         mem_to_reg_M;
  logic         mem_write_M;

  // MEM/WB contents
  logic [N-1:0] alu_out_W;
  logic [N-1:0] read_data_W;
  logic         mem_to_reg_W;

  logic [0:0]    state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;

  logic         mem_op_M;
  logic         is_load_M;
  logic         timeout_hit;
  logic         abort;
  logic         complete;
  logic [N-1:0] load_data;
  logic [N-1:0] store_data;
  logic [3:0]   lane_be;

`ifdef MEM_SUBWORD_EN
  logic [1:0]  mem_size_M;
  logic        mem_unsigned_M;
  logic [7:0]  rd_lane [4];
  logic [3:0]  byte_be;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi] = dmem_rdata[8*gi +: 8];
      assign byte_be[gi] = (alu_out_M[1:0] == 2'(gi));
    end
  endgenerate

  // Half accesses use addr[1] only; word accesses ignore both low bits.
  always_comb begin
    sel_byte   = rd_lane[alu_out_M[1:0]];
    sel_half   = alu_out_M[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    store_data = write_data_M;
    lane_be    = 4'b1111;
    load_data  = dmem_rdata;
    case (mem_size_M)
      2'd0: begin
        store_data = {(N/8){write_data_M[7:0]}};
        lane_be    = byte_be;
        load_data  = mem_unsigned_M ? {{(N-8){1'b0}}, sel_byte}
                                    : {{(N-8){sel_byte[7]}}, sel_byte};
      end
      2'd1: begin
        store_data = {(N/16){write_data_M[15:0]}};
        lane_be    = alu_out_M[1] ? 4'b1100 : 4'b0011;
        load_data  = mem_unsigned_M ? {{(N-16){1'b0}}, sel_half}
                                    : {{(N-16){sel_half[15]}}, sel_half};
      end
      default: ;
    endcase
  end
`else
  assign store_data = write_data_M;
  assign lane_be    = 4'b1111;
  assign load_data  = dmem_rdata;
`endif

  // A load+store flag pair is illegal and resolves to a store.
  assign mem_op_M    = mem_to_reg_M | mem_write_M;
  assign is_load_M   = mem_to_reg_M & ~mem_write_M;
  assign timeout_hit = (state_reg == ST_WAIT) && (count_reg == CW'(TIMEOUT_CYCLES));
  assign abort       = mem_op_M & ~dmem_ready & timeout_hit;
  assign complete    = (mem_op_M & dmem_ready) | abort;

  assign stall_M    = mem_op_M & ~complete;
  assign mem_err    = abort;
  assign dmem_req   = mem_op_M;
  assign dmem_we    = mem_write_M;
  assign dmem_addr  = alu_out_M;
  assign dmem_wdata = store_data;
  assign dmem_be    = lane_be;

  assign result_W = mem_to_reg_W ? read_data_W : alu_out_W;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mem_op_M && !dmem_ready) begin
          state_next = ST_WAIT;
          count_next = CW'(1);
        end
      end
      default: begin
        if (complete) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      alu_out_M    <= '0;
      write_data_M <= '0;
      reg_id_M     <= '0;
      reg_write_M  <= 1'b0;
      mem_to_reg_M <= 1'b0;
      mem_write_M  <= 1'b0;
      alu_out_W    <= '0;
      read_data_W  <= '0;
      mem_to_reg_W <= 1'b0;
      reg_id_W     <= '0;
      reg_write_W  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      // Both pipeline registers freeze together so the bus stays stable during a stall.
      if (!stall_M) begin
        alu_out_M    <= alu_out_E;
        write_data_M <= write_data_E;
        reg_id_M     <= reg_id_E;
        reg_write_M  <= reg_write_E;
        mem_to_reg_M <= mem_to_reg_E;
        mem_write_M  <= mem_write_E;
        alu_out_W    <= alu_out_M;
        read_data_W  <= (is_load_M && !abort) ? load_data : '0;
        mem_to_reg_W <= is_load_M;
        reg_id_W     <= reg_id_M;
        reg_write_W  <= reg_write_M;
      end
    end
  end

`ifdef MEM_SUBWORD_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_size_M     <= 2'd0;
      mem_unsigned_M <= 1'b0;
    end else if (!stall_M) begin
      mem_size_M     <= mem_size_E;
      mem_unsigned_M <= mem_unsigned_E;
    end
  end
`endif

endmodule
